// File: rtl/matrix_mul_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier controller.
package matrix_mul_pkg;

    // Controller phases: buffer the operands, run one MAC per cycle, present one result.
    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StCompute = 2'd1,
        StOut     = 2'd2
    } state_e;

    // Number of A elements (HEIGHT_A rows of WIDTH).
    function automatic int unsigned calc_n_a(input int unsigned height_a,
                                             input int unsigned width);
        return height_a * width;
    endfunction

    // Number of B elements (WIDTH rows of WIDTH_B).
    function automatic int unsigned calc_n_b(input int unsigned width,
                                             input int unsigned width_b);
        return width * width_b;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_seq_unit.sv
// Single multiply-accumulate stage shared by all result elements.
// Build option MATRIX_MUL_SEQ_CTRL_SAT_EN: saturate the running sum at 2^(2*BITS)-1
// instead of wrapping.
module mac_seq_unit
    import matrix_mul_pkg::*;
#(
    parameter int unsigned BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                first,
    input  logic [BITS-1:0]     a,
    input  logic [BITS-1:0]     b,
    output logic [2*BITS-1:0]   acc
);

    localparam int unsigned AW = 2 * BITS;

    logic [AW-1:0] prod;
    logic [AW-1:0] base;
    logic [AW-1:0] acc_d;
`ifdef MATRIX_MUL_SEQ_CTRL_SAT_EN
    logic [AW:0]   sum;
`endif

    // Next accumulator value: restart on the first term of a dot product.
    always_comb begin
        prod = AW'(a) * AW'(b);
        base = first ? '0 : acc;
`ifdef MATRIX_MUL_SEQ_CTRL_SAT_EN
        sum   = {1'b0, base} + {1'b0, prod};
        // A saturated sum plus any product carries out again, so it sticks at max.
        acc_d = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
        acc_d = base + prod;
`endif
    end

    // Accumulator register, advanced only while the controller computes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mul_seq_ctrl.sv
// Sequencing controller computing C = A x B with one shared MAC, one result element at a time.
// Saturating accumulation is selected by MATRIX_MUL_SEQ_CTRL_SAT_EN (handled in mac_seq_unit).
module matrix_mul_seq_ctrl
    import matrix_mul_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned HEIGHT_A = 2,
    parameter int unsigned WIDTH_B  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*BITS-1:0]   out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int unsigned NA = calc_n_a(HEIGHT_A, WIDTH);
    localparam int unsigned NB = calc_n_b(WIDTH, WIDTH_B);
    localparam int unsigned NT = NA + NB;
    localparam int unsigned LW = cnt_width(NT);
    localparam int unsigned IW = cnt_width(HEIGHT_A);
    localparam int unsigned JW = cnt_width(WIDTH_B);
    localparam int unsigned KW = cnt_width(WIDTH);

    localparam logic [LW-1:0] LoadLast = LW'(NT - 1);
    localparam logic [IW-1:0] ILast    = IW'(HEIGHT_A - 1);
    localparam logic [JW-1:0] JLast    = JW'(WIDTH_B - 1);
    localparam logic [KW-1:0] KLast    = KW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;

    // Operand buffer: A row-major in slots 0..NA-1, B row-major after it.
    logic [BITS-1:0] buf_q [NT];

    logic [LW-1:0]   a_idx;
    logic [LW-1:0]   b_idx;
    logic            load_fire;
    logic            mac_en;
    logic            mac_first;
    logic [2*BITS-1:0] acc;

    // Handshake-derived outputs; in_ready stays low while reset is asserted.
    always_comb begin
        in_ready  = (state_q == StLoad) && reset;
        out_valid = (state_q == StOut);
        busy      = (state_q != StLoad);
        out_last  = out_valid && (i_q == ILast) && (j_q == JLast);
        out_data  = out_valid ? acc : '0;
        load_fire = in_valid && in_ready && !clear;
        mac_en    = (state_q == StCompute) && !clear;
        mac_first = (k_q == '0);
        a_idx     = LW'(i_q) * LW'(WIDTH) + LW'(k_q);
        b_idx     = LW'(NA) + LW'(k_q) * LW'(WIDTH_B) + LW'(j_q);
    end

    // Operand storage; deliberately not reset since every load overwrites it fully.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_q[load_cnt_q] <= in_data;
        end
    end

    // Next-state and counter sequencing; clear overrides any handshake.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        if (clear) begin
            state_d    = StLoad;
            load_cnt_d = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (load_fire) begin
                        if (load_cnt_q == LoadLast) begin
                            load_cnt_d = '0;
                            state_d    = StCompute;
                            i_d        = '0;
                            j_d        = '0;
                            k_d        = '0;
                        end else begin
                            load_cnt_d = load_cnt_q + 1'b1;
                        end
                    end
                end
                StCompute: begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        state_d = StOut;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_d = StLoad;
                            i_d     = '0;
                            j_d     = '0;
                        end else begin
                            state_d = StCompute;
                            if (j_q == JLast) begin
                                j_d = '0;
                                i_d = i_q + 1'b1;
                            end else begin
                                j_d = j_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
        end
    end

    mac_seq_unit #(
        .BITS (BITS)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .first (mac_first),
        .a     (buf_q[a_idx]),
        .b     (buf_q[b_idx]),
        .acc   (acc)
    );

endmodule

// File: tb/tb_matrix_mul_seq_ctrl.sv
// Self-checking bench for matrix_mul_seq_ctrl: reference results come from plain
// dot-product arithmetic over the matrices the bench streams in.
module tb_matrix_mul_seq_ctrl;

    localparam int unsigned BITS     = 4;
    localparam int unsigned WIDTH    = 3;
    localparam int unsigned HEIGHT_A = 2;
    localparam int unsigned WIDTH_B  = 3;
    localparam int unsigned NA = HEIGHT_A * WIDTH;
    localparam int unsigned NB = WIDTH * WIDTH_B;
    localparam int unsigned NT = NA + NB;
    localparam int unsigned NC = HEIGHT_A * WIDTH_B;
    localparam int unsigned OW = 2 * BITS;
    localparam int          OMAX = (1 << OW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            out_ready = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic            out_last;
    logic            busy;

    typedef struct {
        int   data;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   mat[NT];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   recv = 0;

    logic          hold_v = 1'b0;
    logic [OW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;

    matrix_mul_seq_ctrl #(
        .BITS     (BITS),
        .WIDTH    (WIDTH),
        .HEIGHT_A (HEIGHT_A),
        .WIDTH_B  (WIDTH_B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], then wrapped or clamped to 2*BITS bits.
    // The sum only grows, so clamping once at the end equals clamping every step.
    task automatic model_push();
        for (int i = 0; i < HEIGHT_A; i++) begin
            for (int j = 0; j < WIDTH_B; j++) begin
                int   s;
                exp_t e;
                s = 0;
                for (int k = 0; k < WIDTH; k++) begin
                    s += mat[i * WIDTH + k] * mat[NA + k * WIDTH_B + j];
                end
`ifdef MATRIX_MUL_SEQ_CTRL_SAT_EN
                if (s > OMAX) s = OMAX;
`else
                s = s % (OMAX + 1);
`endif
                e.data = s;
                e.last = (i == HEIGHT_A - 1) && (j == WIDTH_B - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_nominal();
        int nom[NT];
        nom = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3, 4, 5, 6};
        for (int n = 0; n < NT; n++) mat[n] = nom[n];
    endtask

    task automatic set_random();
        for (int n = 0; n < NT; n++) mat[n] = int'($urandom_range(0, (1 << BITS) - 1));
    endtask

    // Stream the first cnt elements of mat; returns #1 after the edge accepting the last.
    task automatic send_matrix(input int cnt, input int max_gap);
        for (int n = 0; n < cnt; n++) begin
            int  gap;
            int  t;
            logic acc;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = BITS'(mat[n]);
            t = 0;
            forever begin
                acc = in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                t++;
                if (t > 200) begin
                    timeout_fail("in_accept_timeout");
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after the last accept edge E: out_valid rises exactly after E+WIDTH.
    task automatic check_latency(input string name);
        for (int t = 1; t <= WIDTH; t++) begin
            @(posedge clk);
            #1;
            check(name, out_valid, (t == WIDTH) ? 1 : 0);
        end
    endtask

    task automatic drain(input bit rnd);
        int t;
        t = 0;
        while (exp_q.size() != 0) begin
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) begin
                timeout_fail("drain_timeout");
                exp_q.delete();
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic wait_recv(input int target);
        int t;
        t = 0;
        while (recv < target) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 1000) begin
                timeout_fail("recv_timeout");
                break;
            end
        end
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        while (!out_valid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 200) begin
                timeout_fail("out_valid_timeout");
                break;
            end
        end
    endtask

    // Compare process: every result handshake against the model, plus hold and gating rules.
    always @(negedge clk) begin
        if (reset && !clear) begin
            if (busy) check("in_ready_while_busy", in_ready, 0);
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
                check("hold_last", out_last, hold_l);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_output");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    recv++;
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        int base;
        int l0;
        int lits[NC];
        lits = '{21, 27, 33, 57, 72, 87};

        // Reset state, held low for a few cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Nominal matrices, model pinned by hand-computed values.
        set_nominal();
        model_push();
        for (int n = 0; n < NC; n++) begin
            check("model_nominal", exp_q[n].data, lits[n]);
            check("model_nominal_last", exp_q[n].last, (n == NC - 1) ? 1 : 0);
        end
        out_ready = 1'b1;
        send_matrix(NT, 0);
        check_latency("nominal_latency");
        drain(1'b0);

        // Overflow: all 15s give 675 per element.
        for (int n = 0; n < NT; n++) mat[n] = 15;
        model_push();
`ifdef MATRIX_MUL_SEQ_CTRL_SAT_EN
        check("model_overflow", exp_q[0].data, 255);
`else
        check("model_overflow", exp_q[0].data, 163);
`endif
        send_matrix(NT, 2);
        drain(1'b1);

        // Backpressure on element 2 for five cycles.
        set_nominal();
        model_push();
        out_ready = 1'b0;
        send_matrix(NT, 0);
        wait_out_valid();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_out_valid();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 27);
            @(posedge clk);
            #1;
        end
        drain(1'b0);

        // Input gating: in_valid held high through COMPUTE and OUT.
        set_random();
        model_push();
        out_ready = 1'b0;
        send_matrix(NT, 3);
        in_valid = 1'b1;
        in_data  = BITS'($urandom);
        wait_out_valid();
        repeat (4) begin
            check("gate_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain(1'b1);

        // Async reset during COMPUTE of element 4, then a full reload.
        set_nominal();
        model_push();
        out_ready = 1'b1;
        base = recv;
        send_matrix(NT, 0);
        wait_recv(base + 3);
        check("abort_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_push();
        send_matrix(NT, 1);
        drain(1'b1);

        // Clear during a partial load; the element offered with clear must not count.
        set_nominal();
        send_matrix(5, 0);
        in_valid = 1'b1;
        in_data  = BITS'(mat[5]);
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_out_valid", out_valid, 0);
        check("clear_in_ready", in_ready, 1);
        model_push();
        send_matrix(NT, 0);
        drain(1'b0);

        // Back-to-back: second load starts on the edge after out_last is accepted.
        set_random();
        model_push();
        out_ready = 1'b1;
        base = recv;
        send_matrix(NT, 0);
        wait_recv(base + NC);
        check("b2b_in_ready", in_ready, 1);
        set_random();
        model_push();
        l0 = cyc;
        send_matrix(NT, 0);
        check("b2b_load_cycles", cyc - l0, NT);
        check_latency("b2b_latency");
        drain(1'b0);

        // Random matrices with random gaps and stalls.
        for (int r = 0; r < 4; r++) begin
            set_random();
            model_push();
            send_matrix(NT, 2);
            drain(1'b1);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
